// File: rtl/dot_accumulator_if.sv
// Handshake bundle for dot_accumulator: the partial-sum input stream and the
// result output stream. The master modport is the producer/consumer side and
// the slave modport is the accumulator itself.
interface dot_accumulator_if #(
    parameter int W_ACC = 48,
    parameter int CNT_W = 9
);
    logic             in_valid;
    logic [31:0]      in_data;
    logic             in_last;
    logic             in_ready;
    logic             out_valid;
    logic             out_ready;
    logic [W_ACC-1:0] out_data;
    logic [CNT_W-1:0] out_count;
    logic             out_ovf;
    logic             out_err;

    modport master (
        output in_valid, in_data, in_last, out_ready,
        input  in_ready, out_valid, out_data, out_count, out_ovf, out_err
    );

    modport slave (
        input  in_valid, in_data, in_last, out_ready,
        output in_ready, out_valid, out_data, out_count, out_ovf, out_err
    );
endinterface

// File: rtl/dot_accumulator.sv
// dot_accumulator: sums a valid-qualified stream of signed 32-bit partial sums
// into one dot product per vector, with element count and overflow / length
// error flags, and holds a finished result under valid/ready while the next
// vector accumulates.
// Optional build macro SATURATE_EN: overflowing steps clamp to the signed
// extremes instead of wrapping (out_ovf is reported either way).
//
// state | meaning
// ACCUM | result register empty, elements accepted freely
// HOLD  | result register holds an unconsumed result (out_valid = 1)
module dot_accumulator #(
    parameter int W_ACC   = 48,
    parameter int MAX_LEN = 256,
    parameter int CNT_W   = 9
) (
    input logic              clk,
    input logic              rst,
    dot_accumulator_if.slave s_bus
);
    typedef enum logic {ACCUM = 1'b0, HOLD = 1'b1} state_t;

    localparam logic [W_ACC-1:0] SAT_MAX = {1'b0, {(W_ACC-1){1'b1}}};
    localparam logic [W_ACC-1:0] SAT_MIN = {1'b1, {(W_ACC-1){1'b0}}};
    localparam logic [CNT_W-1:0] CNT_CLOSE = CNT_W'(MAX_LEN - 1);

    state_t           r_state;
    logic [W_ACC-1:0] r_acc;
    logic [CNT_W-1:0] r_cnt;
    logic             r_ovf;
    logic             r_out_valid;
    logic [W_ACC-1:0] r_out_data;
    logic [CNT_W-1:0] r_out_count;
    logic             r_out_ovf;
    logic             r_out_err;

    logic             w_in_ready;
    logic             w_accept;
    logic             w_close;
    logic [W_ACC-1:0] w_ext;
    logic [W_ACC-1:0] w_sum;
    logic             w_step_ovf;
    logic [W_ACC-1:0] w_next_acc;

    // Ready drops only while a held result is not being taken this cycle.
    assign w_in_ready = (r_state == ACCUM) || s_bus.out_ready;
    assign w_accept   = s_bus.in_valid && w_in_ready;
    assign w_close    = s_bus.in_last || (r_cnt == CNT_CLOSE);

    assign w_ext      = {{(W_ACC-32){s_bus.in_data[31]}}, s_bus.in_data};
    assign w_sum      = r_acc + w_ext;
    assign w_step_ovf = (r_acc[W_ACC-1] == w_ext[W_ACC-1]) &&
                        (w_sum[W_ACC-1] != r_acc[W_ACC-1]);

    // Next accumulator value: clamp on overflow when saturating, else wrap.
`ifdef SATURATE_EN
    assign w_next_acc = !w_step_ovf     ? w_sum   :
                        r_acc[W_ACC-1]  ? SAT_MIN : SAT_MAX;
`else
    assign w_next_acc = w_sum;
`endif

    // Single FSM: accumulation state plus the registered result stage.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ACCUM;
            r_acc       <= '0;
            r_cnt       <= '0;
            r_ovf       <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_count <= '0;
            r_out_ovf   <= 1'b0;
            r_out_err   <= 1'b0;
        end else begin
            // Consumption first; a closing accept in the same cycle overrides
            // it and reloads the result register.
            if (r_state == HOLD && s_bus.out_ready) begin
                r_state     <= ACCUM;
                r_out_valid <= 1'b0;
            end
            if (w_accept) begin
                if (w_close) begin
                    r_out_data  <= w_next_acc;
                    r_out_count <= r_cnt + CNT_W'(1);
                    r_out_ovf   <= r_ovf | w_step_ovf;
                    r_out_err   <= !s_bus.in_last;
                    r_out_valid <= 1'b1;
                    r_state     <= HOLD;
                    r_acc       <= '0;
                    r_cnt       <= '0;
                    r_ovf       <= 1'b0;
                end else begin
                    r_acc <= w_next_acc;
                    r_cnt <= r_cnt + CNT_W'(1);
                    r_ovf <= r_ovf | w_step_ovf;
                end
            end
        end
    end

    assign s_bus.in_ready  = w_in_ready;
    assign s_bus.out_valid = r_out_valid;
    assign s_bus.out_data  = r_out_data;
    assign s_bus.out_count = r_out_count;
    assign s_bus.out_ovf   = r_out_ovf;
    assign s_bus.out_err   = r_out_err;
endmodule

// File: tb/tb_dot_accumulator.sv
// Directed bench for dot_accumulator: a default-width instance (W_ACC 48,
// MAX_LEN 256) and a narrow instance (W_ACC 33, MAX_LEN 4) for the overflow
// and length-limit cases.
module tb_dot_accumulator;
    logic clk;
    logic rst;

    int checks = 0;
    int errors = 0;

    dot_accumulator_if #(.W_ACC(48), .CNT_W(9)) m_if ();
    dot_accumulator_if #(.W_ACC(33), .CNT_W(3)) s_if ();

    dot_accumulator #(.W_ACC(48), .MAX_LEN(256), .CNT_W(9)) u_main (
        .clk  (clk),
        .rst  (rst),
        .s_bus(m_if.slave)
    );

    dot_accumulator #(.W_ACC(33), .MAX_LEN(4), .CNT_W(3)) u_small (
        .clk  (clk),
        .rst  (rst),
        .s_bus(s_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        v;
        logic [31:0] d;
        logic        l;
        logic        ordy;
        logic        e_rdy;
        logic        e_ov;
        logic [47:0] e_data;
        int          e_cnt;
        logic        e_ovf;
        logic        e_err;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(logic v, int d, logic l, logic ordy, logic e_rdy,
                                logic e_ov, longint e_data, int e_cnt,
                                logic e_ovf, logic e_err);
        vec_t r;
        r.v = v; r.d = d[31:0]; r.l = l; r.ordy = ordy; r.e_rdy = e_rdy;
        r.e_ov = e_ov; r.e_data = e_data[47:0]; r.e_cnt = e_cnt;
        r.e_ovf = e_ovf; r.e_err = e_err;
        return r;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_m(input logic v, input logic [31:0] d, input logic l, input logic ordy);
        m_if.in_valid = v; m_if.in_data = d; m_if.in_last = l; m_if.out_ready = ordy;
    endtask

    task automatic drive_s(input logic v, input logic [31:0] d, input logic l, input logic ordy);
        s_if.in_valid = v; s_if.in_data = d; s_if.in_last = l; s_if.out_ready = ordy;
    endtask

    task automatic chk_m(input string tag, input logic ov, input logic [47:0] data,
                         input int cnt, input logic ovf, input logic err);
        chk({tag, ".valid"}, 64'(m_if.out_valid), 64'(ov));
        chk({tag, ".data"},  64'(m_if.out_data),  64'(data));
        chk({tag, ".count"}, 64'(m_if.out_count), 64'(cnt[8:0]));
        chk({tag, ".ovf"},   64'(m_if.out_ovf),   64'(ovf));
        chk({tag, ".err"},   64'(m_if.out_err),   64'(err));
    endtask

    task automatic chk_s(input string tag, input logic ov, input logic [32:0] data,
                         input int cnt, input logic ovf, input logic err);
        chk({tag, ".valid"}, 64'(s_if.out_valid), 64'(ov));
        chk({tag, ".data"},  64'(s_if.out_data),  64'(data));
        chk({tag, ".count"}, 64'(s_if.out_count), 64'(cnt[2:0]));
        chk({tag, ".ovf"},   64'(s_if.out_ovf),   64'(ovf));
        chk({tag, ".err"},   64'(s_if.out_err),   64'(err));
    endtask

    initial begin
        logic [32:0] exp_ovf_data;

        drive_m(1'b0, 32'd0, 1'b0, 1'b1);
        drive_s(1'b0, 32'd0, 1'b0, 1'b1);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        chk_m("reset_m", 1'b0, 48'd0, 0, 1'b0, 1'b0);
        chk("reset_m.in_ready", 64'(m_if.in_ready), 64'd1);
        chk_s("reset_s", 1'b0, 33'd0, 0, 1'b0, 1'b0);

        // Table: v, data, last, out_ready | in_ready, out_valid, data, count, ovf, err
        tbl.push_back(mk(1, 3,  0, 1, 1, 0, 0,   0, 0, 0));
        tbl.push_back(mk(1, -5, 0, 1, 1, 0, 0,   0, 0, 0));
        tbl.push_back(mk(1, 10, 1, 1, 1, 1, 8,   3, 0, 0));
        tbl.push_back(mk(0, 0,  0, 1, 1, 0, 8,   3, 0, 0));
        tbl.push_back(mk(1, 1,  1, 1, 1, 1, 1,   1, 0, 0));
        tbl.push_back(mk(1, 2,  1, 1, 1, 1, 2,   1, 0, 0));
        tbl.push_back(mk(1, 3,  1, 1, 1, 1, 3,   1, 0, 0));
        tbl.push_back(mk(1, 4,  1, 1, 1, 1, 4,   1, 0, 0));
        tbl.push_back(mk(0, 99, 1, 1, 1, 0, 4,   1, 0, 0));
        tbl.push_back(mk(0, 50, 1, 1, 1, 0, 4,   1, 0, 0));
        tbl.push_back(mk(1, -7, 0, 1, 1, 0, 4,   1, 0, 0));
        tbl.push_back(mk(1, -8, 1, 1, 1, 1, -15, 2, 0, 0));
        tbl.push_back(mk(0, 0,  0, 1, 1, 0, -15, 2, 0, 0));

        for (int i = 0; i < tbl.size(); i++) begin
            drive_m(tbl[i].v, tbl[i].d, tbl[i].l, tbl[i].ordy);
            #1;
            chk($sformatf("tbl%0d.in_ready", i), 64'(m_if.in_ready), 64'(tbl[i].e_rdy));
            tick();
            chk_m($sformatf("tbl%0d", i), tbl[i].e_ov, tbl[i].e_data, tbl[i].e_cnt,
                  tbl[i].e_ovf, tbl[i].e_err);
        end

        // Backpressure: held result is stable and nothing is accepted.
        drive_m(1'b1, 32'd7, 1'b1, 1'b0);
        tick();
        chk_m("hold_load", 1'b1, 48'd7, 1, 1'b0, 1'b0);
        drive_m(1'b1, 32'd1, 1'b0, 1'b0);
        for (int k = 0; k < 5; k++) begin
            #1;
            chk($sformatf("hold%0d.in_ready", k), 64'(m_if.in_ready), 64'd0);
            tick();
            chk_m($sformatf("hold%0d", k), 1'b1, 48'd7, 1, 1'b0, 1'b0);
        end
        drive_m(1'b1, 32'd1, 1'b0, 1'b1);
        #1;
        chk("release.in_ready", 64'(m_if.in_ready), 64'd1);
        tick();
        chk("release.valid", 64'(m_if.out_valid), 64'd0);
        drive_m(1'b1, 32'd2, 1'b1, 1'b1);
        tick();
        chk_m("after_hold", 1'b1, 48'd3, 2, 1'b0, 1'b0);
        drive_m(1'b0, 32'd0, 1'b0, 1'b1);
        tick();

        // Narrow instance: overflow on the third step at W_ACC = 33.
`ifdef SATURATE_EN
        exp_ovf_data = 33'h0FFFFFFFF;
`else
        exp_ovf_data = 33'h100000000;
`endif
        drive_s(1'b1, 32'h7FFFFFFF, 1'b0, 1'b1); tick();
        drive_s(1'b1, 32'h7FFFFFFF, 1'b0, 1'b1); tick();
        chk("ovf_mid.valid", 64'(s_if.out_valid), 64'd0);
        drive_s(1'b1, 32'h00000002, 1'b1, 1'b1); tick();
        chk_s("ovf", 1'b1, exp_ovf_data, 3, 1'b1, 1'b0);

        // MAX_LEN = 4: six 1s, last on the sixth.
        for (int k = 1; k <= 6; k++) begin
            drive_s(1'b1, 32'd1, (k == 6), 1'b1);
            tick();
            if (k == 4) chk_s("maxlen_first", 1'b1, 33'd4, 4, 1'b0, 1'b1);
            if (k == 5) chk("maxlen_mid.valid", 64'(s_if.out_valid), 64'd0);
        end
        chk_s("maxlen_second", 1'b1, 33'd2, 2, 1'b0, 1'b0);

        // in_last on the MAX_LEN-th element is a normal close.
        for (int k = 1; k <= 4; k++) begin
            drive_s(1'b1, 32'd1, (k == 4), 1'b1);
            tick();
        end
        chk_s("maxlen_last", 1'b1, 33'd4, 4, 1'b0, 1'b0);
        drive_s(1'b0, 32'd0, 1'b0, 1'b1);
        tick();

        // Reset mid-vector discards the partial sum.
        drive_m(1'b1, 32'd5, 1'b0, 1'b1); tick();
        drive_m(1'b1, 32'd6, 1'b0, 1'b1); tick();
        drive_m(1'b0, 32'd0, 1'b0, 1'b1);
        drive_m(1'b1, 32'd9, 1'b1, 1'b0); tick();
        chk("pre_reset.valid", 64'(m_if.out_valid), 64'd1);
        drive_m(1'b0, 32'd0, 1'b0, 1'b0);
        rst = 1'b1;
        #1;
        chk_m("in_reset", 1'b0, 48'd0, 0, 1'b0, 1'b0);
        chk("in_reset.in_ready", 64'(m_if.in_ready), 64'd1);
        tick();
        rst = 1'b0;
        drive_m(1'b1, 32'd9, 1'b1, 1'b1);
        tick();
        chk_m("post_reset", 1'b1, 48'd9, 1, 1'b0, 1'b0);
        drive_m(1'b0, 32'd0, 1'b0, 1'b1);
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/dot_accumulator.md
# dot_accumulator

- Downstream consumer of the two-lane multiply-add pipeline.
- Takes that stage's 32-bit per-cycle partial sums (A1·B1 + A2·B2) as a valid-qualified stream, accumulates them over one vector, and emits the full dot product with element count and status flags.
- Holds one finished result in an output register under a valid/ready handshake while the next vector accumulates.

## Interface

Parameters:
- W_ACC, 48, accumulator and result width in bits (≥ 33).
- MAX_LEN, 256, maximum elements per vector (≥ 2).
- CNT_W, 9, width of element counter and out_count (must hold MAX_LEN).

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-high; clears all state immediately.
- in_valid  input  1  in_data carries a partial sum this cycle.
- in_data  input  32  partial sum, two's-complement signed.
- in_last  input  1  qualifies the final element of a vector; ignored unless in_valid.
- in_ready  output  1  element accepted when in_valid && in_ready.
- out_valid  output  1  result register holds an unconsumed result.
- out_ready  input  1  consumer takes result when out_valid && out_ready.
- out_data  output  W_ACC  dot product of completed vector.
- out_count  output  CNT_W  elements in completed vector, 1..MAX_LEN.
- out_ovf  output  1  signed overflow occurred at any step of this vector.
- out_err  output  1  vector closed by MAX_LEN limit, not by in_last.

## Operation

- in_data is sign-extended to W_ACC before addition. Running register acc is W_ACC bits wide; running count cnt and sticky ovf are kept per vector.
- Two states:
  - ACCUM: output register empty.
  - HOLD: out_valid = 1.
- in_ready = (state == ACCUM) || out_ready. This is combinational and drops only while a held result is not being taken.
- Accept, non-closing element:
  - acc ← acc + in_data
  - cnt ← cnt + 1
  - ovf ← ovf | step overflow
- Closing element: in_last = 1, or cnt == MAX_LEN−1 without in_last.
  - out_data ← acc + in_data; out_count ← cnt + 1; out_ovf ← ovf | step overflow; out_err ← !in_last.
  - acc, cnt and ovf clear to 0. State goes to HOLD.
- Step overflow: the two operands have equal sign and the sum has a different sign, at W_ACC.
- HOLD, out_ready = 1, no closing accept: out_valid drops next cycle and state returns to ACCUM.
- HOLD, out_ready = 1, closing accept in the same cycle: the result register reloads with the new result and state stays HOLD. Back-to-back single-element vectors sustain one result per cycle.
- HOLD, out_ready = 0: out_data, out_count, out_ovf and out_err are stable, and no input is accepted.
- in_last on the MAX_LEN-th element: a normal close with out_err = 0.
- Reset mid-vector discards the partial accumulation. Reset while in HOLD drops the held result.

## Timing

- Reset values:
  - out_valid 0, out_data 0, out_count 0, out_ovf 0, out_err 0.
  - acc 0, cnt 0, state ACCUM, so in_ready = 1.
- Throughput: one element per cycle while in_ready = 1.
- Latency: out_valid rises on the clock edge that accepts the closing element, so the result is visible the cycle after that element is presented.
- An element offered with in_ready = 0 is not accepted. The producer must hold or re-present it (the upstream multiply-add stage has no stall, so the issuer gates its valid accordingly).

## Configuration

- SATURATE_EN defined:
  - Any step whose signed sum overflows clamps to 2^(W_ACC−1)−1 (positive overflow) or −2^(W_ACC−1) (negative overflow).
  - Later steps continue from the clamped value.
  - out_ovf is still set.
- SATURATE_EN undefined:
  - Sums wrap modulo 2^W_ACC.
  - out_ovf still reports overflow.

## Test plan

- Reset, then feed 3, −5, 10 (last on 10) with out_ready = 1 → out_valid one cycle after the 10 is accepted; out_data = 8, out_count = 3, out_ovf = 0, out_err = 0.
- out_ready held 0 after vector {7} (last); then feed {1, 2} without last → in_ready = 0. The result stays 7/1 for 5 cycles and no element is accepted. Raise out_ready → 7 consumed and 1 accepted in the same cycle.
- Four consecutive single-element vectors 1, 2, 3, 4 (in_last every cycle) with out_ready = 1 → out_valid high for four consecutive cycles; out_data = 1, 2, 3, 4; out_count = 1 each.
- W_ACC = 33, two elements 0x7FFFFFFF then 0x7FFFFFFF, then 0x00000002 last:
  - SATURATE_EN: out_data = 0x0FFFFFFFF and out_ovf = 1.
  - Wrap build: out_data = 0x100000000 (negative) and out_ovf = 1.
- MAX_LEN = 4: feed six 1s, last on the sixth → first result out_data = 4, out_count = 4, out_err = 1; second result out_data = 2, out_count = 2, out_err = 0.
- Feed 5, 6 (no last), assert reset for one cycle, then 9 last → out_data = 9 and out_count = 1. All outputs read 0 during reset.
